uart_tx_arbiter: RTL and testbench

//  Shares one uart_basic transmitter among NUM_REQ requesters using round-robin arbitration.

---
 rtl/uart_tx_arbiter.sv | 156 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one uart_basic transmitter among NUM_REQ sources.
// Define UART_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int BIT_WIDTH    = 8,
  parameter int SINGLE_SEND  = 1,
  parameter int BUSY_TIMEOUT = 15,
  localparam int IDW         = $clog2(NUM_REQ)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*BIT_WIDTH-1:0] data_in,
  output logic [NUM_REQ-1:0]           grant,
  output logic                         uart_send,
  output logic [BIT_WIDTH-1:0]         uart_tx_reg,
  input  logic                         uart_busy,
  output logic                         active,
  output logic [IDW-1:0]               cur_id,
  output logic                         timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SEND,
    S_WAIT_BUSY,
    S_WAIT_DONE
  } state_t;

  state_t               r_state;
  state_t               w_state_n;
  logic [NUM_REQ-1:0]   r_grant;
  logic [NUM_REQ-1:0]   w_grant_n;
  logic                 r_send;
  logic                 w_send_n;
  logic [BIT_WIDTH-1:0] r_tx;
  logic [BIT_WIDTH-1:0] w_tx_n;
  logic [IDW-1:0]       r_id;
  logic [IDW-1:0]       w_id_n;
  logic                 r_tout;
  logic                 w_tout_n;
  logic                 r_active;
  logic [7:0]           r_timer;
  logic [7:0]           w_timer_n;
  logic [IDW-1:0]       w_win;
`ifndef UART_ARB_FIXED_PRIO_EN
  logic [IDW-1:0]       r_rr;
  logic [IDW-1:0]       w_rr_n;
`endif

  // Winner select; scanning farthest-first lets the nearest hit overwrite.
  always_comb begin
    w_win = '0;
`ifdef UART_ARB_FIXED_PRIO_EN
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) w_win = IDW'(i);
    end
`else
    for (int k = NUM_REQ; k >= 1; k--) begin
      int idx;
      idx = (int'(r_rr) + k) % NUM_REQ;
      if (req[idx]) w_win = IDW'(idx);
    end
`endif
  end

  always_comb begin
    w_state_n = r_state;
    w_grant_n = '0;
    w_send_n  = r_send;
    w_tx_n    = r_tx;
    w_id_n    = r_id;
    w_tout_n  = 1'b0;
    w_timer_n = r_timer;
`ifndef UART_ARB_FIXED_PRIO_EN
    w_rr_n    = r_rr;
`endif
    unique case (r_state)
      S_IDLE: begin
        if (|req && !uart_busy) begin
          w_grant_n = NUM_REQ'(1) << w_win;
          w_tx_n    = data_in[w_win*BIT_WIDTH +: BIT_WIDTH];
          w_id_n    = w_win;
          w_state_n = S_LOAD;
        end
      end
      S_LOAD: w_state_n = S_SEND;
      S_SEND: begin
        w_send_n  = (SINGLE_SEND != 0) ? ~r_send : 1'b1;
        w_timer_n = '0;
        w_state_n = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (uart_busy) begin
          if (SINGLE_SEND == 0) w_send_n = 1'b0;
          w_state_n = S_WAIT_DONE;
        end else if (r_timer == 8'(BUSY_TIMEOUT - 1)) begin
          if (SINGLE_SEND == 0) w_send_n = 1'b0;
          w_tout_n  = 1'b1;
`ifndef UART_ARB_FIXED_PRIO_EN
          w_rr_n    = r_id;
`endif
          w_state_n = S_IDLE;
        end else begin
          w_timer_n = r_timer + 8'd1;
        end
      end
      S_WAIT_DONE: begin
        if (!uart_busy) begin
`ifndef UART_ARB_FIXED_PRIO_EN
          w_rr_n    = r_id;
`endif
          w_state_n = S_IDLE;
        end
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_grant  <= '0;
      r_send   <= 1'b0;
      r_tx     <= '0;
      r_id     <= '0;
      r_tout   <= 1'b0;
      r_active <= 1'b0;
      r_timer  <= '0;
`ifndef UART_ARB_FIXED_PRIO_EN
      r_rr     <= IDW'(NUM_REQ - 1);
`endif
    end else begin
      r_state  <= w_state_n;
      r_grant  <= w_grant_n;
      r_send   <= w_send_n;
      r_tx     <= w_tx_n;
      r_id     <= w_id_n;
      r_tout   <= w_tout_n;
      r_active <= (w_state_n != S_IDLE);
      r_timer  <= w_timer_n;
`ifndef UART_ARB_FIXED_PRIO_EN
      r_rr     <= w_rr_n;
`endif
    end
  end

  assign grant       = r_grant;
  assign uart_send   = r_send;
  assign uart_tx_reg = r_tx;
  assign active      = r_active;
  assign cur_id      = r_id;
  assign timeout_err = r_tout;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: toggle-mode and level-mode instances
// driven against simple uart_basic busy models.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = '0;
  logic [31:0] data_in = '0;
  logic [3:0]  grant;
  logic        send;
  logic [7:0]  tx;
  logic        busy;
  logic        active;
  logic [1:0]  cur_id;
  logic        tout;

  logic [3:0]  req2 = '0;
  logic [31:0] data_in2 = '0;
  logic [3:0]  grant2;
  logic        send2;
  logic [7:0]  tx2;
  logic        busy2;
  logic        active2;
  logic [1:0]  cur_id2;
  logic        tout2;

  logic        busy_en = 1'b1;
  logic        busy_force = 1'b0;
  logic [4:0]  bcnt, bcnt2;
  logic        bprev, bprev2;
  int          lvl_words;

  int n_cmp = 0;
  int n_bad = 0;

`ifdef UART_ARB_FIXED_PRIO_EN
  localparam int GEXP[5] = '{0, 0, 0, 0, 0};
`else
  localparam int GEXP[5] = '{0, 1, 2, 3, 0};
`endif

  always #5 clk = ~clk;

  uart_tx_arbiter u_dut (
    .clk(clk), .rst(rst), .req(req), .data_in(data_in),
    .grant(grant), .uart_send(send), .uart_tx_reg(tx),
    .uart_busy(busy), .active(active), .cur_id(cur_id),
    .timeout_err(tout)
  );

  uart_tx_arbiter #(.SINGLE_SEND(0)) u_lvl (
    .clk(clk), .rst(rst), .req(req2), .data_in(data_in2),
    .grant(grant2), .uart_send(send2), .uart_tx_reg(tx2),
    .uart_busy(busy2), .active(active2), .cur_id(cur_id2),
    .timeout_err(tout2)
  );

  // Toggle-mode uart: busy for 10 cycles starting the cycle after send changes
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      bcnt  <= '0;
      bprev <= 1'b0;
    end else begin
      bprev <= send;
      if (busy_en && send != bprev && bcnt == 0) bcnt <= 5'd10;
      else if (bcnt != 0) bcnt <= bcnt - 5'd1;
    end
  end
  assign busy = (bcnt != 0) | busy_force;

  // Level-mode uart: a rising send starts a word
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      bcnt2     <= '0;
      bprev2    <= 1'b0;
      lvl_words <= 0;
    end else begin
      bprev2 <= send2;
      if (send2 && !bprev2 && bcnt2 == 0) begin
        bcnt2     <= 5'd10;
        lvl_words <= lvl_words + 1;
      end else if (bcnt2 != 0) begin
        bcnt2 <= bcnt2 - 5'd1;
      end
    end
  end
  assign busy2 = (bcnt2 != 0);

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_grant(input int lim, output int ncy);
    ncy = -1;
    for (int i = 1; i <= lim; i++) begin
      @(negedge clk);
      if (grant != 0) begin
        ncy = i;
        break;
      end
    end
  endtask

  task automatic wait_grant2(input int lim, output int ncy);
    ncy = -1;
    for (int i = 1; i <= lim; i++) begin
      @(negedge clk);
      if (grant2 != 0) begin
        ncy = i;
        break;
      end
    end
  endtask

  task automatic wait_send(input logic old, input int lim, output int ncy);
    ncy = -1;
    for (int i = 1; i <= lim; i++) begin
      @(negedge clk);
      if (send != old) begin
        ncy = i;
        break;
      end
    end
  endtask

  task automatic wait_idle(input int lim, output int ncy);
    ncy = -1;
    for (int i = 1; i <= lim; i++) begin
      @(negedge clk);
      if (!active) begin
        ncy = i;
        break;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int n;
    logic old;

    // reset values
    tick(2);
    check("rst_grant", grant, 0);
    check("rst_send", send, 0);
    check("rst_tx", tx, 0);
    check("rst_active", active, 0);
    check("rst_cur_id", cur_id, 0);
    check("rst_tout", tout, 0);
    rst = 1'b0;

    // single source, single word
    req = 4'b0001;
    data_in[7:0] = 8'hA5;
    wait_grant(5, n);
    check("t1_grant_lat", n, 1);
    check("t1_grant", grant, 4'b0001);
    check("t1_tx", tx, 8'hA5);
    check("t1_active", active, 1);
    req = '0;
    wait_send(1'b0, 5, n);
    check("t1_send_lat", n, 2);
    check("t1_send", send, 1);
    wait_idle(40, n);
    check("t1_idle", n > 0, 1);
    check("t1_send_hold", send, 1);

    // uart busy in IDLE blocks arbitration
    busy_force = 1'b1;
    req = 4'b0001;
    wait_grant(4, n);
    check("busy_hold_nogrant", n, -1);
    check("busy_hold_idle", active, 0);
    busy_force = 1'b0;
    wait_grant(3, n);
    check("busy_rel_grant", n, 1);
    req = '0;
    wait_idle(40, n);
    check("busy_rel_idle", n > 0, 1);
    check("busy_rel_send", send, 0);

    // all four requesting, from a fresh reset
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    data_in = {8'h44, 8'h33, 8'h22, 8'h11};
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_grant(30, n);
      check($sformatf("t2_seen%0d", k), n > 0, 1);
      check($sformatf("t2_grant%0d", k), grant, 4'b0001 << GEXP[k]);
      check($sformatf("t2_tx%0d", k), tx, 8'((GEXP[k] + 1) * 17));
      if (k == 4) req = '0;
      old = send;
      wait_send(old, 5, n);
      check($sformatf("t2_slat%0d", k), n, 2);
      check($sformatf("t2_send%0d", k), send, (k % 2 == 0) ? 1 : 0);
    end
    wait_idle(40, n);
    check("t2_idle", n > 0, 1);

    // level-mode instance
    req2 = 4'b0100;
    data_in2[23:16] = 8'h5C;
    wait_grant2(5, n);
    check("t3_grant_lat", n, 1);
    check("t3_grant", grant2, 4'b0100);
    check("t3_tx", tx2, 8'h5C);
    req2 = '0;
    tick(2);
    check("t3_send_hi", send2, 1);
    tick(1);
    check("t3_send_hold", send2, 1);
    tick(1);
    check("t3_send_lo", send2, 0);
    check("t3_active", active2, 1);
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (!active2) begin
        n = i;
        break;
      end
    end
    check("t3_idle", n > 0, 1);
    check("t3_words", lvl_words, 1);
    check("t3_send_end", send2, 0);

    // busy never rises: timeout
    busy_en = 1'b0;
    req = 4'b0010;
    wait_grant(5, n);
    check("t4_grant", grant, 4'b0010);
    req = '0;
    old = send;
    wait_send(old, 5, n);
    check("t4_slat", n, 2);
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (tout) begin
        n = i;
        break;
      end
    end
    check("t4_tout_lat", n, 15);
    check("t4_tout_idle", active, 0);
    tick(1);
    check("t4_tout_pulse", tout, 0);
    busy_en = 1'b1;
    req = 4'b0101;
    wait_grant(5, n);
`ifdef UART_ARB_FIXED_PRIO_EN
    check("t4_next_grant", grant, 4'b0001);
`else
    check("t4_next_grant", grant, 4'b0100);
`endif
    req = '0;
    wait_idle(40, n);
    check("t4_idle", n > 0, 1);

    // reset during WAIT_DONE
    data_in[31:24] = 8'h99;
    req = 4'b1000;
    wait_grant(5, n);
    check("t5_grant", grant, 4'b1000);
    req = '0;
    tick(8);
    check("t5_busy_phase", active, 1);
    rst = 1'b1;
    #1;
    check("t5_rst_outs", {grant, send, tx, active, cur_id, tout}, 0);
    tick(1);
    rst = 1'b0;
    wait_grant(3, n);
    check("t5_no_stale", n, -1);
    req = 4'b1001;
    wait_grant(5, n);
    check("t5_restart", grant, 4'b0001);
    req = '0;
    wait_idle(40, n);
    check("t5_idle", n > 0, 1);

`ifdef UART_ARB_FIXED_PRIO_EN
    // fixed priority: source 3 starves
    req = 4'b1010;
    for (int k = 0; k < 3; k++) begin
      wait_grant(30, n);
      check($sformatf("t6_grant%0d", k), grant, 4'b0010);
    end
    req = '0;
    wait_idle(40, n);
    check("t6_idle", n > 0, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
